imem_loader: RTL and testbench

//  Write-side counterpart of the instruction ROM. Receives a program as a byte

---
 rtl/imem_loader_pkg.sv | 36 +++
 rtl/imem_loader_packer.sv | 55 +++++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - state_t        : loader FSM states, also exported on the debug port
//   - MAGIC_DEFAULT  : frame start byte
//   - DEPTH_DEFAULT  : instruction memory size in words
//   - LEN_W          : width of the frame length field (word count)
//   - BYTES_PER_WORD : stream bytes packed into one instruction word
//   - accepts_bytes(): states in which the loader takes stream bytes
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
  localparam int         DEPTH_DEFAULT  = 128;
  localparam int         LEN_W          = 16;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_WORD = WORD_W / 8;

  // The loader keeps taking bytes until the frame has reached a terminal
  // state; DONE and ERR park the stream until the next reset.
  function automatic logic accepts_bytes(input state_t s);
    return (s == IDLE) || (s == LEN_LO) || (s == LEN_HI) ||
           (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Packs a byte stream little-endian into 32-bit words. The first byte of a
//   word ends up in bits [7:0], the fourth in bits [31:24].
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   clr         : drop any partial word (start of a new frame)
//   push        : a byte is presented on din and must be absorbed this cycle
//   din [7:0]   : stream byte
//   word [31:0] : last completed word, held until the next word completes
//   word_valid  : one-cycle pulse, the cycle after the 4th byte was pushed
//   word_last   : combinational, high in the cycle the 4th byte is pushed
// -----------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  logic [1:0]        byte_cnt;
  // Holds the first three bytes of the word in flight; newest byte on top so
  // that the fourth byte simply lands above it in the completed word.
  logic [WORD_W-9:0] sr;

  assign word_last = push && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (clr) begin
        byte_cnt <= 2'd0;
        sr       <= '0;
      end else if (push) begin
        byte_cnt <= byte_cnt + 2'd1;
        sr       <= {din, sr[WORD_W-9:8]};
        if (word_last) begin
          word <= {din, sr};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a program image as a framed byte stream and writes it into the
//   instruction memory, keeping the CPU in reset until a complete image with
//   a matching checksum has been loaded.
//
//   Frame: MAGIC, LEN_LO, LEN_HI (word count N), 4*N data bytes (LE per word),
//          CSUM (XOR of all data bytes). N > DEPTH is rejected before any
//          write; N == 0 goes straight to the checksum byte.
//
//   Handshake: a byte moves when in_valid && in_ready on a rising clk edge.
//   in_ready is decoded from the registered state only, never from in_valid;
//   in_data is ignored in any cycle without a transfer, and an idle cycle has
//   no side effects in any state.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid, in_data : stream byte offered by the source
//   in_ready          : loader can take a byte (all non-terminal states)
//   imem_we           : one-cycle write strobe, cycle after a word completes
//   imem_waddr        : word index of the write
//   imem_wdata        : instruction word of the write
//   words_loaded      : words written in the current frame
//   load_done         : image loaded and checksum good (sticky until rst)
//   load_err          : length or checksum error (sticky until rst)
//   cpu_hold          : 1 keeps the core in reset (everything but DONE)
//   dbg_state         : current FSM state
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int         DEPTH  = DEPTH_DEFAULT,
  parameter  logic [7:0] MAGIC  = MAGIC_DEFAULT,
  localparam int         ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              load_done,
  output logic              load_err,
  output logic              cpu_hold,
  output state_t            dbg_state
);

  localparam logic [LEN_W:0]  DEPTH_LEN = (LEN_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;

  logic              xfer;
  logic              frame_start;
  logic              data_push;
  logic              last_word;

  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_rx;
  logic [LEN_W-1:0]  wl_next;
  logic [7:0]        csum;

  logic [WORD_W-1:0] pk_word;
  logic              pk_valid;
  logic              pk_last;

  assign xfer        = in_valid && in_ready;
  assign frame_start = xfer && (state == IDLE) && (in_data == MAGIC);
  assign data_push   = xfer && (state == DATA);

  // Full length as it stands in the cycle the high byte is accepted.
  assign len_rx  = {in_data, len_lo};

  // The word completing this cycle is the last one when the count of words
  // written, including this one, reaches N.
  assign wl_next   = LEN_W'(words_loaded) + LEN_W'(1);
  assign last_word = pk_last && (wl_next == len);

  // ---------------------------------------------------------------------------
  // Byte packing
  // ---------------------------------------------------------------------------
  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (frame_start),
    .push       (data_push),
    .din        (in_data),
    .word       (pk_word),
    .word_valid (pk_valid),
    .word_last  (pk_last)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Every transition is gated by a transfer, so a stalled
  // source leaves the state untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (xfer) begin
      unique case (state)
        IDLE: begin
          if (in_data == MAGIC) begin
            state_nxt = LEN_LO;
          end
        end
        LEN_LO: begin
          state_nxt = LEN_HI;
        end
        LEN_HI: begin
          // Rejecting oversize images here is what keeps the word index from
          // ever wrapping inside DATA.
          if ({1'b0, len_rx} > DEPTH_LEN) begin
            state_nxt = ERR;
          end else if (len_rx == '0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (last_word) begin
            state_nxt = CSUM;
          end
        end
        CSUM: begin
          if (in_data == csum) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ERR;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath: length, checksum, write index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo       <= 8'd0;
      len          <= '0;
      csum         <= 8'd0;
      words_loaded <= '0;
      imem_waddr   <= '0;
    end else begin
      if (frame_start) begin
        csum         <= 8'd0;
        words_loaded <= '0;
      end
      if (xfer && (state == LEN_LO)) begin
        len_lo <= in_data;
      end
      if (xfer && (state == LEN_HI)) begin
        len <= len_rx;
      end
      if (data_push) begin
        csum <= csum ^ in_data;
      end
      // Address and count move together with the packer's word register so
      // all three line up in the write cycle.
      if (pk_last) begin
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + WL_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_we    = pk_valid;
  assign imem_wdata = pk_word;
  assign in_ready   = accepts_bytes(state);
  assign load_done  = (state == DONE);
  assign load_err   = (state == ERR);
  assign cpu_hold   = (state != DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed frames plus randomized frames for imem_loader. Expected writes
//   live in exp_q ({word index, word}); a negedge monitor pops one entry per
//   imem_we pulse, so any missing, wrong or extra write is reported.
//   Randomized frames are scored by a frame parser (run_model) that works
//   straight from the frame format on the byte list.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int         DEPTH  = 128;
  localparam int         ADDR_W = $clog2(DEPTH);
  localparam logic [7:0] MAGIC  = 8'hA5;
  localparam int         EXP_W  = ADDR_W + 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;
  logic              load_done;
  logic              load_err;
  logic              cpu_hold;
  state_t            dbg_state;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .load_done    (load_done),
    .load_err     (load_err),
    .cpu_hold     (cpu_hold),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int               checks = 0;
  int               errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       stim_q[$];
  logic             exp_done;
  logic             exp_err;
  int               exp_words;
  logic [EXP_W-1:0] mon_exp;

  // Write monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_we: got addr=%0d data=%h, required no write", imem_waddr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   imem_waddr, imem_wdata, mon_exp[EXP_W-1:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: parse stim_q as a frame
  // ---------------------------------------------------------------------------
  task automatic run_model();
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    i = 0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    while (i < stim_q.size() && stim_q[i] != MAGIC) i++;
    if (i + 2 >= stim_q.size()) return;
    n = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
    i += 3;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w = w | (32'(stim_q[i]) << (8 * b));
        x = x ^ stim_q[i];
        i++;
      end
      exp_q.push_back({ADDR_W'(k), w});
      exp_words++;
    end
    if (i < stim_q.size()) begin
      if (stim_q[i] == x) exp_done = 1'b1;
      else                exp_err  = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int waited;
    if (max_gap > 0) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_stream(input int max_gap);
    foreach (stim_q[i]) send_byte(stim_q[i], max_gap);
  endtask

  // Frame from the first directed case; its checksum is the XOR of the data.
  task automatic load_frame1(input logic [7:0] csum_delta);
    logic [7:0] x;
    stim_q = '{MAGIC, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    x = 8'd0;
    for (int i = 3; i < 11; i++) x = x ^ stim_q[i];
    stim_q.push_back(x ^ csum_delta);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks += 9;
    if (in_ready !== 1'b1)        begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    if (imem_we !== 1'b0)         begin errors++; $display("FAIL rst_we: got %b, required 0", imem_we); end
    if (imem_waddr !== '0)        begin errors++; $display("FAIL rst_waddr: got %0d, required 0", imem_waddr); end
    if (imem_wdata !== 32'd0)     begin errors++; $display("FAIL rst_wdata: got %h, required 0", imem_wdata); end
    if (words_loaded !== '0)      begin errors++; $display("FAIL rst_words: got %0d, required 0", words_loaded); end
    if (load_done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b, required 0", load_done); end
    if (load_err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b, required 0", load_err); end
    if (cpu_hold !== 1'b1)        begin errors++; $display("FAIL rst_hold: got %b, required 1", cpu_hold); end
    if (dbg_state !== IDLE)       begin errors++; $display("FAIL rst_state: got %0d, required IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    do_reset();
    load_frame1(8'h00);
    exp_q.push_back({ADDR_W'(0), 32'h00000013});
    exp_q.push_back({ADDR_W'(1), 32'h00100093});
    foreach (stim_q[i]) begin
      send_byte(stim_q[i], 0);
      if (i == 6) begin
        checks += 3;
        if (imem_we !== 1'b1)      begin errors++; $display("FAIL basic_latency_we: got %b, required 1", imem_we); end
        if (imem_wdata !== 32'h13) begin errors++; $display("FAIL basic_latency_data: got %h, required 00000013", imem_wdata); end
        if (words_loaded !== 1)    begin errors++; $display("FAIL basic_latency_words: got %0d, required 1", words_loaded); end
      end
      if (i == 7) begin
        checks++;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL basic_we_width: got %b, required 0", imem_we); end
      end
    end
    idle_cycles(3);
    checks += 6;
    if (load_done !== 1'b1)  begin errors++; $display("FAIL basic_done: got %b, required 1", load_done); end
    if (load_err !== 1'b0)   begin errors++; $display("FAIL basic_err: got %b, required 0", load_err); end
    if (cpu_hold !== 1'b0)   begin errors++; $display("FAIL basic_hold: got %b, required 0", cpu_hold); end
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL basic_ready: got %b, required 0", in_ready); end
    if (words_loaded !== 2)  begin errors++; $display("FAIL basic_words: got %0d, required 2", words_loaded); end
    if (exp_q.size() != 0)   begin errors++; $display("FAIL basic_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_len_err();
    do_reset();
    stim_q = '{MAGIC, 8'h81, 8'h00};
    send_stream(0);
    idle_cycles(6);
    checks += 5;
    if (load_err !== 1'b1)  begin errors++; $display("FAIL len_err: got %b, required 1", load_err); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL len_done: got %b, required 0", load_done); end
    if (cpu_hold !== 1'b1)  begin errors++; $display("FAIL len_hold: got %b, required 1", cpu_hold); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL len_ready: got %b, required 0", in_ready); end
    if (words_loaded !== 0) begin errors++; $display("FAIL len_words: got %0d, required 0", words_loaded); end
  endtask

  task automatic test_csum_err();
    do_reset();
    load_frame1(8'h11);
    exp_q.push_back({ADDR_W'(0), 32'h00000013});
    exp_q.push_back({ADDR_W'(1), 32'h00100093});
    send_stream(0);
    idle_cycles(3);
    checks += 5;
    if (load_err !== 1'b1)  begin errors++; $display("FAIL csum_err: got %b, required 1", load_err); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL csum_done: got %b, required 0", load_done); end
    if (cpu_hold !== 1'b1)  begin errors++; $display("FAIL csum_hold: got %b, required 1", cpu_hold); end
    if (words_loaded !== 2) begin errors++; $display("FAIL csum_words: got %0d, required 2", words_loaded); end
    if (exp_q.size() != 0)  begin errors++; $display("FAIL csum_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_junk();
    do_reset();
    stim_q = '{8'h00, 8'hFF, MAGIC, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
    send_stream(0);
    idle_cycles(3);
    checks += 4;
    if (load_done !== 1'b1) begin errors++; $display("FAIL junk_done: got %b, required 1", load_done); end
    if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL junk_hold: got %b, required 0", cpu_hold); end
    if (words_loaded !== 1) begin errors++; $display("FAIL junk_words: got %0d, required 1", words_loaded); end
    if (exp_q.size() != 0)  begin errors++; $display("FAIL junk_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    stim_q = '{MAGIC, 8'h02, 8'h00, 8'h13, 8'h00};
    send_stream(0);
    do_reset();
    checks += 2;
    if (words_loaded !== 0) begin errors++; $display("FAIL mid_words: got %0d, required 0", words_loaded); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d, required IDLE", dbg_state); end
    load_frame1(8'h00);
    exp_q.push_back({ADDR_W'(0), 32'h00000013});
    exp_q.push_back({ADDR_W'(1), 32'h00100093});
    send_stream(0);
    idle_cycles(3);
    checks += 3;
    if (load_done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b, required 1", load_done); end
    if (words_loaded !== 2) begin errors++; $display("FAIL mid_final_words: got %0d, required 2", words_loaded); end
    if (exp_q.size() != 0)  begin errors++; $display("FAIL mid_pending: got %0d writes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      load_frame1(8'h00);
      exp_q.push_back({ADDR_W'(0), 32'h00000013});
      exp_q.push_back({ADDR_W'(1), 32'h00100093});
      send_stream(4);
      idle_cycles(5);
      checks += 3;
      if (load_done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b, required 1", load_done); end
      if (words_loaded !== 2) begin errors++; $display("FAIL gaps_words: got %0d, required 2", words_loaded); end
      if (exp_q.size() != 0)  begin errors++; $display("FAIL gaps_pending: got %0d writes missing, required 0", exp_q.size()); end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] x;
    // N == DEPTH: the last write lands at DEPTH-1.
    do_reset();
    stim_q = '{MAGIC, 8'(DEPTH), 8'(DEPTH >> 8)};
    x = 8'd0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      stim_q.push_back(8'($urandom));
      x = x ^ stim_q[stim_q.size() - 1];
    end
    stim_q.push_back(x);
    run_model();
    send_stream(0);
    idle_cycles(3);
    checks += 3;
    if (load_done !== 1'b1)     begin errors++; $display("FAIL full_done: got %b, required 1", load_done); end
    if (words_loaded !== DEPTH) begin errors++; $display("FAIL full_words: got %0d, required %0d", words_loaded, DEPTH); end
    if (exp_q.size() != 0)      begin errors++; $display("FAIL full_pending: got %0d writes missing, required 0", exp_q.size()); end
    // N == 0: empty image, checksum of nothing is zero.
    do_reset();
    stim_q = '{MAGIC, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    idle_cycles(3);
    checks += 2;
    if (load_done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b, required 1", load_done); end
    if (words_loaded !== 0) begin errors++; $display("FAIL empty_words: got %0d, required 0", words_loaded); end
  endtask

  task automatic test_random();
    int n;
    int kind;
    logic [7:0] x;
    logic [7:0] j;
    for (int r = 0; r < 10; r++) begin
      do_reset();
      stim_q.delete();
      repeat ($urandom_range(0, 3)) begin
        j = 8'($urandom);
        if (j == MAGIC) j = 8'h00;
        stim_q.push_back(j);
      end
      kind = $urandom_range(0, 4);
      n = (kind == 0) ? $urandom_range(DEPTH + 1, 1000) : $urandom_range(1, 12);
      stim_q.push_back(MAGIC);
      stim_q.push_back(8'(n));
      stim_q.push_back(8'(n >> 8));
      if (kind != 0) begin
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
          stim_q.push_back(8'($urandom));
          x = x ^ stim_q[stim_q.size() - 1];
        end
        if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
        stim_q.push_back(x);
      end
      run_model();
      send_stream(2);
      idle_cycles(3);
      checks += 5;
      if (load_done !== exp_done)  begin errors++; $display("FAIL rand_done: got %b, required %b", load_done, exp_done); end
      if (load_err !== exp_err)    begin errors++; $display("FAIL rand_err: got %b, required %b", load_err, exp_err); end
      if (cpu_hold !== !exp_done)  begin errors++; $display("FAIL rand_hold: got %b, required %b", cpu_hold, !exp_done); end
      if (words_loaded !== exp_words) begin errors++; $display("FAIL rand_words: got %0d, required %0d", words_loaded, exp_words); end
      if (exp_q.size() != 0)       begin errors++; $display("FAIL rand_pending: got %0d writes missing, required 0", exp_q.size()); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_len_err();
    test_csum_err();
    test_junk();
    test_midframe_reset();
    test_gaps();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
